shift_writeback: RTL and testbench
==================================

# shift_writeback

Writeback stage directly downstream of the Gumnut shift unit. It captures each shifter result (8-bit result plus carry-out) into a one-entry holding register under a valid/ready handshake, then commits it to the 8×8 register file and the Z/C flag registers. It also provides the register read port that feeds the shifter's `rs` operand, with a bypass from the pending entry so that back-to-back dependent shifts never read stale data.

## Interface
Parameters:
- `DATA_W`, 8: datapath width. Gumnut fixes this at 8; other values are unsupported.
- `REG_N`, 8: number of registers. Address width is `$clog2(REG_N)` = 3.

Ports:
- `clk_i`, in, 1: single clock; all state updates on the rising edge.
- `rst_i`, in, 1: reset, synchronous, active-high.
- `valid_i`, in, 1: shifter result is valid this cycle.
- `ready_o`, out, 1: stage accepts the result this cycle.
- `rd_i`, in, 3: destination register.
- `res_i`, in, 8: shifter result.
- `cout_i`, in, 1: shifter carry-out.
- `stall_i`, in, 1: core holds off commit (register-file port claimed elsewhere).
- `flush_i`, in, 1: squash the pending entry and any incoming entry.
- `rs_addr_i`, in, 3: read address for the shifter operand.
- `rs_o`, out, 8: read data, bypassed.
- `z_o`, out, 1: zero flag.
- `c_o`, out, 1: carry flag.
- `commit_o`, out, 1: high in the cycle a commit occurs.

## Operation
- State:
  - holding register `{hv, hrd[2:0], hres[7:0], hc}`;
  - register file `rf[0..7]`;
  - flags `Z`, `C`.
- Accept: `valid_i && ready_o && !flush_i` at an edge loads the holding register and sets `hv=1`.
- `ready_o = !rst_i && (!hv || commit)`. A full holding register can therefore accept a new entry in the same cycle it commits.
- Commit condition: `commit = hv && !stall_i && !flush_i && !rst_i`. `commit_o` equals `commit`.
- On the commit edge:
  - `rf[hrd] <= hres`, unless `hrd==0`, in which case the write is discarded;
  - `Z <= (hres==8'h00)`;
  - `C <= hc`;
  - `hv <= 0`, unless a new entry is accepted on the same edge.
- Flags update even when `hrd==0` (compare-style use of r0).
- Rotates reach this stage with `cout_i=0`, so they clear C. No special casing is needed.
- Read port, combinational:
  - `rs_o = 0` if `rs_addr_i==0`;
  - otherwise `hres` if `hv && hrd==rs_addr_i`;
  - otherwise `rf[rs_addr_i]`.
- Flush: `hv <= 0` with no commit and no flag change. An incoming `valid_i` in the same cycle is dropped. Flush has priority over both stall and accept.
- Stall: the holding register is retained, `ready_o=0` while `hv=1`, and the bypass stays active.

## Timing
- Reset, at the first edge with `rst_i=1`:
  - `rf[*]=0`, `Z=0`, `C=0`, `hv=0`;
  - `ready_o=0` while `rst_i` is high;
  - `commit_o=0`, `rs_o=0` for all addresses, `z_o=0`, `c_o=0`.
- Reset mid-operation: a pending entry is discarded with no register or flag write.
- Latency:
  - result accepted at edge N;
  - visible on `rs_o` through the bypass from cycle N+1;
  - committed at edge N+1 if unstalled;
  - visible from `rf` and on `z_o`/`c_o` from cycle N+2.
- Throughput: one result per cycle with no stalls.
- Simultaneous commit and accept: the old entry goes to `rf` and the new entry to the holding register. The bypass then reflects the new entry.
- Same `rd` back-to-back: the second write wins. The bypass always shows the youngest value.
- `stall_i` is ignored when `hv=0`.

## Structure
- Shared package `gumnut_pkg`:
  - `DATA_W`, `REG_ADDR_W=3`;
  - ALU shift opcode constants (SHL=2'b00, SHR=2'b01, ROL=2'b10, ROR=2'b11);
  - flag index constants `FLAG_Z=0`, `FLAG_C=1`.
- Sub-module `gumnut_regfile`:
  - one synchronous write port and one asynchronous read port;
  - r0 hardwired to zero.
- The top level holds the holding register, flags, handshake and bypass mux.

## Test plan
- Reset: drive `rst_i=1` for 2 cycles → `ready_o=0`, `z_o=0`, `c_o=0`, `rs_o=0` for all 8 addresses, and `ready_o=1` the cycle after release.
- Basic: `res_i=8'h80`, `cout_i=1`, `rd_i=3` → `rs_o(3)=8'h80` at N+1 via bypass; at N+2 `c_o=1`, `z_o=0`, `rf[3]=8'h80`.
- Zero/r0: `res_i=0`, `cout_i=0`, `rd_i=0` → `commit_o=1`, `z_o=1`, `c_o=0`, and `rs_o(0)` stays 0.
- Back-to-back: `rd_i=5` with values 8'h11 then 8'h22 on consecutive cycles → `ready_o` stays 1, the bypass shows 8'h22 at N+2, and `rf[5]=8'h22`.
- Stall: `stall_i=1` for 3 cycles with a pending entry → `ready_o=0`, `commit_o=0`, bypass held, flags unchanged. Release → commit on the next edge.
- Flush/reset: flush with a pending entry and a simultaneous `valid_i` → no commit, `hv=0`, flags and `rf` unchanged. Repeat with `rst_i` in place of flush → no write occurs.

Source files
------------

// File: rtl/gumnut_pkg.sv
// Shared Gumnut definitions: datapath width, register address width,
// shifter opcode encodings and flag bit positions within the flag vector.
package gumnut_pkg;

  localparam int DATA_W     = 8;
  localparam int REG_ADDR_W = 3;

  // Shift unit opcodes
  localparam logic [1:0] SHL = 2'b00;
  localparam logic [1:0] SHR = 2'b01;
  localparam logic [1:0] ROL = 2'b10;
  localparam logic [1:0] ROR = 2'b11;

  // Bit positions in the packed {C, Z} flag register
  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;

endpackage

// File: rtl/gumnut_regfile.sv
// Gumnut register file: one synchronous write port, one asynchronous read
// port. r0 has no storage; it always reads as zero and writes to it vanish.
// Ports:
//   clk_i, rst_i   clock and synchronous active-high reset (clears all regs)
//   we_i           write enable
//   waddr_i/wdata_i write address / data
//   raddr_i        read address
//   rdata_o        read data (combinational)
module gumnut_regfile #(
  parameter int DATA_W = 8,
  parameter int REG_N  = 8,
  localparam int AW    = $clog2(REG_N)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem [1:REG_N-1];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 1; i < REG_N; i++) mem[i] <= '0;
    end else if (we_i && (waddr_i != '0)) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = (raddr_i == '0) ? '0 : mem[raddr_i];

endmodule

// File: rtl/shift_writeback.sv
// Writeback stage behind the Gumnut shift unit. A one-entry holding register
// captures each shifter result under valid/ready, then commits it to the
// register file and Z/C flags. The rs read port bypasses the pending entry
// so a dependent shift issued the next cycle sees the youngest value.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   valid_i / ready_o   result handshake
//   rd_i, res_i, cout_i destination register, result, carry-out
//   stall_i             hold off commit (holding register retained)
//   flush_i             squash pending and incoming entries
//   rs_addr_i / rs_o    operand read port with bypass
//   z_o, c_o            zero and carry flags
//   commit_o            high in the cycle a commit happens
module shift_writeback #(
  parameter int DATA_W = 8,
  parameter int REG_N  = 8,
  localparam int AW    = $clog2(REG_N)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [AW-1:0]     rd_i,
  input  logic [DATA_W-1:0] res_i,
  input  logic              cout_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic [AW-1:0]     rs_addr_i,
  output logic [DATA_W-1:0] rs_o,
  output logic              z_o,
  output logic              c_o,
  output logic              commit_o
);

  import gumnut_pkg::*;

  logic              hv;
  logic [AW-1:0]     hrd;
  logic [DATA_W-1:0] hres;
  logic              hc;
  logic [1:0]        flags;

  logic              commit;
  logic              accept;
  logic [DATA_W-1:0] rf_rdata;

  // Flush outranks both stall and accept; a committing entry frees the slot
  // in the same cycle so full-rate streaming needs only one entry.
  assign commit   = hv && !stall_i && !flush_i && !rst_i;
  assign ready_o  = !rst_i && (!hv || commit);
  assign accept   = valid_i && ready_o && !flush_i;
  assign commit_o = commit;

  // Holding register control and flags
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hv    <= 1'b0;
      flags <= '0;
    end else begin
      if (accept)                  hv <= 1'b1;
      else if (commit || flush_i)  hv <= 1'b0;
      // Flags update even for r0 targets so r0 can act as a compare sink.
      if (commit) begin
        flags[FLAG_Z] <= (hres == '0);
        flags[FLAG_C] <= hc;
      end
    end
  end

  // Holding register payload; qualified by hv so no reset is needed.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      hrd  <= rd_i;
      hres <= res_i;
      hc   <= cout_i;
    end
  end

  gumnut_regfile #(
    .DATA_W (DATA_W),
    .REG_N  (REG_N)
  ) u_regfile (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (commit),
    .waddr_i (hrd),
    .wdata_i (hres),
    .raddr_i (rs_addr_i),
    .rdata_o (rf_rdata)
  );

  always_comb begin
    rs_o = rf_rdata;
    if (rs_addr_i == '0)               rs_o = '0;
    else if (hv && (hrd == rs_addr_i)) rs_o = hres;
  end

  assign z_o = flags[FLAG_Z];
  assign c_o = flags[FLAG_C];

endmodule

// File: tb/tb_shift_writeback.sv
// Directed bench for shift_writeback: a per-cycle vector table with
// hand-computed expectations plus hand-written reset and streaming sequences.
module tb_shift_writeback;

  logic       clk = 1'b0;
  logic       rst_i, valid_i, ready_o, cout_i, stall_i, flush_i;
  logic       z_o, c_o, commit_o;
  logic [2:0] rd_i, rs_addr_i;
  logic [7:0] res_i, rs_o;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  shift_writeback dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .rd_i      (rd_i),
    .res_i     (res_i),
    .cout_i    (cout_i),
    .stall_i   (stall_i),
    .flush_i   (flush_i),
    .rs_addr_i (rs_addr_i),
    .rs_o      (rs_o),
    .z_o       (z_o),
    .c_o       (c_o),
    .commit_o  (commit_o)
  );

  typedef struct packed {
    logic       rst;
    logic       valid;
    logic [2:0] rd;
    logic [7:0] res;
    logic       cout;
    logic       stall;
    logic       flush;
    logic [2:0] rs;
    logic       e_ready;
    logic       e_commit;
    logic [7:0] e_rs;
    logic       e_z;
    logic       e_c;
  } vec_t;

  localparam int NV = 25;
  vec_t vecs [NV];

  function automatic vec_t mk(logic rst, logic valid, logic [2:0] rd,
                              logic [7:0] res, logic cout, logic stall,
                              logic flush, logic [2:0] rs, logic e_ready,
                              logic e_commit, logic [7:0] e_rs, logic e_z,
                              logic e_c);
    vec_t v;
    v.rst = rst; v.valid = valid; v.rd = rd; v.res = res; v.cout = cout;
    v.stall = stall; v.flush = flush; v.rs = rs; v.e_ready = e_ready;
    v.e_commit = e_commit; v.e_rs = e_rs; v.e_z = e_z; v.e_c = e_c;
    return v;
  endfunction

  task automatic check(input string name, input int idx,
                       input logic [7:0] act, input logic [7:0] exp);
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s [%0d]: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic valid, input logic [2:0] rd,
                       input logic [7:0] res, input logic cout,
                       input logic stall, input logic flush,
                       input logic [2:0] rs);
    rst_i = rst; valid_i = valid; rd_i = rd; res_i = res; cout_i = cout;
    stall_i = stall; flush_i = flush; rs_addr_i = rs;
  endtask

  initial begin
    //                 rst val rd  res    co st fl rs   rdy cmt rs     z  c
    // after reset
    vecs[0]  = mk(0, 0, 3'd0, 8'h00, 0, 0, 0, 3'd3, 1, 0, 8'h00, 0, 0);
    // basic: r3 <= 80, carry 1
    vecs[1]  = mk(0, 1, 3'd3, 8'h80, 1, 0, 0, 3'd3, 1, 0, 8'h00, 0, 0);
    vecs[2]  = mk(0, 0, 3'd0, 8'h00, 0, 0, 0, 3'd3, 1, 1, 8'h80, 0, 0);
    vecs[3]  = mk(0, 0, 3'd0, 8'h00, 0, 0, 0, 3'd3, 1, 0, 8'h80, 0, 1);
    // zero result to r0: flags update, r0 stays 0
    vecs[4]  = mk(0, 1, 3'd0, 8'h00, 0, 0, 0, 3'd0, 1, 0, 8'h00, 0, 1);
    vecs[5]  = mk(0, 0, 3'd0, 8'h00, 0, 0, 0, 3'd0, 1, 1, 8'h00, 0, 1);
    vecs[6]  = mk(0, 0, 3'd0, 8'h00, 0, 0, 0, 3'd0, 1, 0, 8'h00, 1, 0);
    // back-to-back r5: 11 then 22
    vecs[7]  = mk(0, 1, 3'd5, 8'h11, 0, 0, 0, 3'd5, 1, 0, 8'h00, 1, 0);
    vecs[8]  = mk(0, 1, 3'd5, 8'h22, 1, 0, 0, 3'd5, 1, 1, 8'h11, 1, 0);
    vecs[9]  = mk(0, 0, 3'd0, 8'h00, 0, 0, 0, 3'd5, 1, 1, 8'h22, 0, 0);
    vecs[10] = mk(0, 0, 3'd0, 8'h00, 0, 0, 0, 3'd5, 1, 0, 8'h22, 0, 1);
    // stall 3 cycles with r2 <= 40 pending; offered valid is refused
    vecs[11] = mk(0, 1, 3'd2, 8'h40, 0, 0, 0, 3'd2, 1, 0, 8'h00, 0, 1);
    vecs[12] = mk(0, 1, 3'd2, 8'h99, 1, 1, 0, 3'd2, 0, 0, 8'h40, 0, 1);
    vecs[13] = mk(0, 1, 3'd2, 8'h99, 1, 1, 0, 3'd2, 0, 0, 8'h40, 0, 1);
    vecs[14] = mk(0, 1, 3'd2, 8'h99, 1, 1, 0, 3'd2, 0, 0, 8'h40, 0, 1);
    vecs[15] = mk(0, 0, 3'd0, 8'h00, 0, 0, 0, 3'd2, 1, 1, 8'h40, 0, 1);
    vecs[16] = mk(0, 0, 3'd0, 8'h00, 0, 0, 0, 3'd2, 1, 0, 8'h40, 0, 0);
    // flush pending r6 <= 5A plus simultaneous valid
    vecs[17] = mk(0, 1, 3'd6, 8'h5A, 1, 0, 0, 3'd6, 1, 0, 8'h00, 0, 0);
    vecs[18] = mk(0, 1, 3'd6, 8'h77, 1, 0, 1, 3'd6, 0, 0, 8'h5A, 0, 0);
    vecs[19] = mk(0, 0, 3'd0, 8'h00, 0, 0, 0, 3'd6, 1, 0, 8'h00, 0, 0);
    vecs[20] = mk(0, 0, 3'd0, 8'h00, 0, 0, 0, 3'd6, 1, 0, 8'h00, 0, 0);
    // reset with pending r7 <= 3C plus simultaneous valid
    vecs[21] = mk(0, 1, 3'd7, 8'h3C, 1, 0, 0, 3'd7, 1, 0, 8'h00, 0, 0);
    vecs[22] = mk(1, 1, 3'd7, 8'hAA, 1, 0, 0, 3'd7, 0, 0, 8'h3C, 0, 0);
    vecs[23] = mk(0, 0, 3'd0, 8'h00, 0, 0, 0, 3'd7, 1, 0, 8'h00, 0, 0);
    vecs[24] = mk(0, 0, 3'd0, 8'h00, 0, 0, 0, 3'd3, 1, 0, 8'h00, 0, 0);

    // Reset: two cycles high, checked during the second
    drive(1, 0, 3'd0, 8'h00, 0, 0, 0, 3'd0);
    @(negedge clk);
    @(negedge clk);
    #1;
    vec_cnt++;
    check("rst_ready", 0, {7'd0, ready_o}, 8'h00);
    check("rst_z", 0, {7'd0, z_o}, 8'h00);
    check("rst_c", 0, {7'd0, c_o}, 8'h00);
    check("rst_commit", 0, {7'd0, commit_o}, 8'h00);
    for (int a = 0; a < 8; a++) begin
      rs_addr_i = 3'(a);
      #1;
      check("rst_rs", a, rs_o, 8'h00);
    end

    // Table-driven vectors: one cycle each, checked before the rising edge
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].valid, vecs[i].rd, vecs[i].res,
            vecs[i].cout, vecs[i].stall, vecs[i].flush, vecs[i].rs);
      #1;
      vec_cnt++;
      check("ready", i, {7'd0, ready_o}, {7'd0, vecs[i].e_ready});
      check("commit", i, {7'd0, commit_o}, {7'd0, vecs[i].e_commit});
      check("rs", i, rs_o, vecs[i].e_rs);
      check("z", i, {7'd0, z_o}, {7'd0, vecs[i].e_z});
      check("c", i, {7'd0, c_o}, {7'd0, vecs[i].e_c});
    end

    // Full-rate stream r1..r7 <= a*0x11, then read every register back
    for (int a = 1; a < 8; a++) begin
      @(negedge clk);
      drive(0, 1, 3'(a), 8'(a * 17), 0, 0, 0, 3'(a));
      #1;
      vec_cnt++;
      check("stream_ready", a, {7'd0, ready_o}, 8'h01);
      check("stream_commit", a, {7'd0, commit_o}, (a > 1) ? 8'h01 : 8'h00);
    end
    @(negedge clk);
    drive(0, 0, 3'd0, 8'h00, 0, 0, 0, 3'd0);
    #1;
    vec_cnt++;
    check("drain_commit", 0, {7'd0, commit_o}, 8'h01);
    @(negedge clk);
    for (int a = 0; a < 8; a++) begin
      rs_addr_i = 3'(a);
      #1;
      vec_cnt++;
      check("stream_rf", a, rs_o, 8'(a * 17));
    end
    check("stream_z", 0, {7'd0, z_o}, 8'h00);
    check("stream_c", 0, {7'd0, c_o}, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
